// File: rtl/udma_uart_tx_sequencer.sv
// Config-bus master for the uDMA UART: per start pulse it programs SETUP and the TX channel,
// polls until transmission drains, reads ERROR, and clears the channel on abort or timeout.
module udma_uart_tx_sequencer #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int TIMEOUT_W      = 16,
    parameter int POLL_GAP       = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [15:0]               div_i,
    input  logic [1:0]                num_bits_i,
    input  logic                      parity_en_i,
    input  logic                      stop_bits_i,
    input  logic [L2_AWIDTH_NOAL-1:0] buf_addr_i,
    input  logic [TRANS_SIZE-1:0]     buf_size_i,
    input  logic [TIMEOUT_W-1:0]      timeout_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic                      aborted_o,
    output logic [1:0]                err_o,
    output logic [31:0]               cfg_data_o,
    output logic [4:0]                cfg_addr_o,
    output logic                      cfg_valid_o,
    output logic                      cfg_rwn_o,
    input  logic [31:0]               cfg_data_i,
    input  logic                      cfg_ready_i
);
    localparam int              GW       = $clog2(POLL_GAP) + 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(POLL_GAP - 1);
    localparam logic [4:0]      A_SADDR  = 5'd4;
    localparam logic [4:0]      A_SIZE   = 5'd5;
    localparam logic [4:0]      A_CFG    = 5'd6;
    localparam logic [4:0]      A_STATUS = 5'd8;
    localparam logic [4:0]      A_SETUP  = 5'd9;
    localparam logic [4:0]      A_ERROR  = 5'd10;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        W_SETUP = 4'd1,
        W_SADDR = 4'd2,
        W_SIZE  = 4'd3,
        W_CFG   = 4'd4,
        GAP     = 4'd5,
        P_CFG   = 4'd6,
        GAP2    = 4'd7,
        P_STAT  = 4'd8,
        R_ERR   = 4'd9,
        CLR     = 4'd10,
        DONE    = 4'd11
    } state_e;

    function automatic logic [31:0] setup_word(input logic [15:0] div, input logic [1:0] bits,
                                               input logic par, input logic stop);
        setup_word = {div, 6'h00, 1'b1, 1'b1, 4'h0, stop, bits, par};
    endfunction

    state_e                    state_q, state_d;
    logic [15:0]               div_q, div_d;
    logic [1:0]                bits_q, bits_d;
    logic                      par_q, par_d;
    logic                      stop_q, stop_d;
    logic [L2_AWIDTH_NOAL-1:0] baddr_q, baddr_d;
    logic [TRANS_SIZE-1:0]     size_q, size_d;
    logic [TIMEOUT_W-1:0]      tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0]      tcnt_q, tcnt_d;
    logic [GW-1:0]             gap_q, gap_d;
    logic                      timeout_q, timeout_d;
    logic                      aborted_q, aborted_d;
    logic [1:0]                err_q, err_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      valid_q, valid_d;
    logic                      rwn_q, rwn_d;
    logic [4:0]                caddr_q, caddr_d;
    logic [31:0]               cdata_q, cdata_d;
    logic                      xfer_s, poll_s, tmo_hit_s, abortable_s;
    logic                      unused_rdata_s;

    assign unused_rdata_s = ^cfg_data_i[31:6];

    // Next-state, captured-job and status-flag logic.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bits_d    = bits_q;
        par_d     = par_q;
        stop_d    = stop_q;
        baddr_d   = baddr_q;
        size_d    = size_q;
        tmo_d     = tmo_q;
        tcnt_d    = tcnt_q;
        gap_d     = gap_q;
        timeout_d = timeout_q;
        aborted_d = aborted_q;
        err_d     = err_q;

        xfer_s      = valid_q & cfg_ready_i;
        poll_s      = (state_q == GAP) || (state_q == P_CFG) || (state_q == GAP2) || (state_q == P_STAT);
        tmo_hit_s   = poll_s && (tmo_q != '0) && (tcnt_q == tmo_q);
        abortable_s = (state_q != IDLE) && (state_q != DONE) && (state_q != CLR);

        if (poll_s && (tcnt_q != '1)) begin
            tcnt_d = tcnt_q + 1'b1;
        end else begin
            tcnt_d = tcnt_q;
        end

        if (abort_i && abortable_s) begin
            state_d   = CLR;
            aborted_d = 1'b1;
        end else if (tmo_hit_s) begin
            state_d   = CLR;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = W_SETUP;
                        div_d     = div_i;
                        bits_d    = num_bits_i;
                        par_d     = parity_en_i;
                        stop_d    = stop_bits_i;
                        baddr_d   = buf_addr_i;
                        size_d    = buf_size_i;
                        tmo_d     = timeout_i;
                        timeout_d = 1'b0;
                        aborted_d = 1'b0;
                        err_d     = 2'b00;
                    end else begin
                        state_d = IDLE;
                    end
                end
                W_SETUP: begin
                    if (xfer_s) begin
                        state_d = (size_q == '0) ? R_ERR : W_SADDR;
                    end else begin
                        state_d = W_SETUP;
                    end
                end
                W_SADDR: state_d = xfer_s ? W_SIZE : W_SADDR;
                W_SIZE:  state_d = xfer_s ? W_CFG : W_SIZE;
                W_CFG: begin
                    if (xfer_s) begin
                        state_d = GAP;
                        gap_d   = '0;
                        tcnt_d  = '0;
                    end else begin
                        state_d = W_CFG;
                    end
                end
                GAP, GAP2: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = (state_q == GAP) ? P_CFG : P_STAT;
                        gap_d   = '0;
                    end else begin
                        gap_d   = gap_q + 1'b1;
                    end
                end
                P_CFG: begin
                    if (xfer_s) begin
                        state_d = (cfg_data_i[5] | cfg_data_i[4]) ? GAP : GAP2;
                        gap_d   = '0;
                    end else begin
                        state_d = P_CFG;
                    end
                end
                P_STAT: begin
                    if (xfer_s) begin
                        state_d = cfg_data_i[0] ? GAP2 : R_ERR;
                        gap_d   = '0;
                    end else begin
                        state_d = P_STAT;
                    end
                end
                R_ERR: begin
                    if (xfer_s) begin
                        state_d = DONE;
                        err_d   = cfg_data_i[1:0];
                    end else begin
                        state_d = R_ERR;
                    end
                end
                CLR:     state_d = xfer_s ? DONE : CLR;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Bus and status outputs decoded from the upcoming state so they leave the block registered.
    always_comb begin
        valid_d = 1'b0;
        rwn_d   = 1'b0;
        caddr_d = 5'd0;
        cdata_d = 32'd0;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        case (state_d)
            W_SETUP: begin
                valid_d = 1'b1;
                caddr_d = A_SETUP;
                cdata_d = setup_word(div_d, bits_d, par_d, stop_d);
            end
            W_SADDR: begin
                valid_d = 1'b1;
                caddr_d = A_SADDR;
                cdata_d = 32'(baddr_d);
            end
            W_SIZE: begin
                valid_d = 1'b1;
                caddr_d = A_SIZE;
                cdata_d = 32'(size_d);
            end
            W_CFG: begin
                valid_d = 1'b1;
                caddr_d = A_CFG;
                cdata_d = 32'h0000_0010;
            end
            P_CFG: begin
                valid_d = 1'b1;
                rwn_d   = 1'b1;
                caddr_d = A_CFG;
            end
            P_STAT: begin
                valid_d = 1'b1;
                rwn_d   = 1'b1;
                caddr_d = A_STATUS;
            end
            R_ERR: begin
                valid_d = 1'b1;
                rwn_d   = 1'b1;
                caddr_d = A_ERROR;
            end
            CLR: begin
                // The first CLR cycle keeps valid low so an abandoned transfer is visibly dropped.
                valid_d = (state_q == CLR);
                caddr_d = A_CFG;
                cdata_d = 32'h0000_0020;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // State, captured job parameters, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            div_q     <= 16'd0;
            bits_q    <= 2'd0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            baddr_q   <= '0;
            size_q    <= '0;
            tmo_q     <= '0;
            tcnt_q    <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            rwn_q     <= 1'b0;
            caddr_q   <= 5'd0;
            cdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bits_q    <= bits_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            baddr_q   <= baddr_d;
            size_q    <= size_d;
            tmo_q     <= tmo_d;
            tcnt_q    <= tcnt_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            rwn_q     <= rwn_d;
            caddr_q   <= caddr_d;
            cdata_q   <= cdata_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign aborted_o   = aborted_q;
    assign err_o       = err_q;
    assign cfg_valid_o = valid_q;
    assign cfg_rwn_o   = rwn_q;
    assign cfg_addr_o  = caddr_q;
    assign cfg_data_o  = cdata_q;

endmodule

// File: tb/tb_udma_uart_tx_sequencer.sv
// Directed bench for udma_uart_tx_sequencer: a UART register model answers the config bus,
// expected transactions are queued per job and compared against the observed bus log.
module tb_udma_uart_tx_sequencer;
    localparam int AW = 12;
    localparam int SW = 16;
    localparam int TW = 16;
    localparam int PG = 4;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [15:0]   div_i = 16'd0;
    logic [1:0]    num_bits_i = 2'd0;
    logic          parity_en_i = 1'b0;
    logic          stop_bits_i = 1'b0;
    logic [AW-1:0] buf_addr_i = '0;
    logic [SW-1:0] buf_size_i = '0;
    logic [TW-1:0] timeout_i = '0;
    logic          busy_o, done_o, timeout_o, aborted_o;
    logic [1:0]    err_o;
    logic [31:0]   cfg_data_o;
    logic [4:0]    cfg_addr_o;
    logic          cfg_valid_o, cfg_rwn_o;
    logic [31:0]   cfg_data_i = 32'd0;
    logic          cfg_ready_i = 1'b0;

    udma_uart_tx_sequencer #(
        .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(SW), .TIMEOUT_W(TW), .POLL_GAP(PG)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
        .div_i(div_i), .num_bits_i(num_bits_i), .parity_en_i(parity_en_i),
        .stop_bits_i(stop_bits_i), .buf_addr_i(buf_addr_i), .buf_size_i(buf_size_i),
        .timeout_i(timeout_i), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .aborted_o(aborted_o), .err_o(err_o), .cfg_data_o(cfg_data_o),
        .cfg_addr_o(cfg_addr_o), .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
        .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef logic [37:0] txn_t;   // {rwn, addr, write data (0 for reads)}
    txn_t exp_q[$];
    txn_t obs_q[$];
    int   idle_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    int         stall_n = 0;
    int         pend_n = 0;
    int         busy_n = 0;
    bit         stuck = 1'b0;
    logic [1:0] err_val = 2'b00;
    int         cfg_rd_cnt = 0;
    int         stat_rd_cnt = 0;
    int         hold_cnt = 0;
    int         idle_run = 0;
    txn_t       last_bus = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic txn_t wr(input logic [4:0] a, input logic [31:0] d);
        wr = {1'b0, a, d};
    endfunction

    function automatic txn_t rd(input logic [4:0] a);
        rd = {1'b1, a, 32'd0};
    endfunction

    // UART register model: stalls each transfer stall_n cycles, then answers.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            cfg_ready_i = 1'b0;
            hold_cnt    = 0;
        end else if (cfg_valid_o) begin
            if (hold_cnt > 0) chk("stall_stable", {cfg_rwn_o, cfg_addr_o, cfg_data_o}, last_bus);
            last_bus = {cfg_rwn_o, cfg_addr_o, cfg_data_o};
            if (hold_cnt < stall_n) begin
                cfg_ready_i = 1'b0;
                hold_cnt++;
            end else begin
                cfg_ready_i = 1'b1;
                hold_cnt    = 0;
                if (cfg_addr_o == 5'd6)       cfg_data_i = (stuck || cfg_rd_cnt < pend_n) ? 32'h30 : 32'h0;
                else if (cfg_addr_o == 5'd8)  cfg_data_i = (stat_rd_cnt < busy_n) ? 32'h1 : 32'h0;
                else if (cfg_addr_o == 5'd10) cfg_data_i = {30'd0, err_val};
                else                          cfg_data_i = 32'd0;
            end
        end else begin
            cfg_ready_i = 1'b0;
            hold_cnt    = 0;
            if (busy_o) idle_run++;
        end
    end

    // Bus log: every completed transfer with the idle cycles that preceded it.
    always @(posedge clk_i) begin
        if (rstn_i && cfg_valid_o && cfg_ready_i) begin
            obs_q.push_back({cfg_rwn_o, cfg_addr_o, cfg_rwn_o ? 32'd0 : cfg_data_o});
            idle_q.push_back(idle_run);
            idle_run = 0;
            if (cfg_rwn_o && cfg_addr_o == 5'd6) cfg_rd_cnt++;
            if (cfg_rwn_o && cfg_addr_o == 5'd8) stat_rd_cnt++;
        end
    end

    task automatic push_normal(input logic [31:0] setup, input logic [AW-1:0] a,
                               input logic [SW-1:0] s, input int np, input int nb);
        exp_q.push_back(wr(5'd9, setup));
        if (s != '0) begin
            exp_q.push_back(wr(5'd4, 32'(a)));
            exp_q.push_back(wr(5'd5, 32'(s)));
            exp_q.push_back(wr(5'd6, 32'h10));
            for (int i = 0; i <= np; i++) exp_q.push_back(rd(5'd6));
            for (int i = 0; i <= nb; i++) exp_q.push_back(rd(5'd8));
        end
        exp_q.push_back(rd(5'd10));
    endtask

    task automatic run_job(input string tag, input logic [15:0] dv, input logic [1:0] nb,
                           input logic pe, input logic sb, input logic [AW-1:0] a,
                           input logic [SW-1:0] s, input logic [TW-1:0] t);
        cfg_rd_cnt  = 0;
        stat_rd_cnt = 0;
        @(negedge clk_i);
        div_i = dv; num_bits_i = nb; parity_en_i = pe; stop_bits_i = sb;
        buf_addr_i = a; buf_size_i = s; timeout_i = t;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({tag, "_busy"}, busy_o, 1'b1);
        chk({tag, "_flags_clr"}, {timeout_o, aborted_o, err_o}, 4'b0000);
    endtask

    task automatic wait_done(input string tag, input bit abort_at_done);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
        if (seen) begin
            if (abort_at_done) abort_i = 1'b1;
            @(negedge clk_i);
            abort_i = 1'b0;
            chk({tag, "_done_pulse"}, {done_o, busy_o}, 2'b00);
        end
    endtask

    task automatic cmp_q(input string tag);
        txn_t e;
        txn_t o;
        int   g;
        chk({tag, "_ntxn"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            g = idle_q.pop_front();
            chk({tag, "_txn"}, o, e);
            if (e[37] && (e[36:32] == 5'd6 || e[36:32] == 5'd8)) chk({tag, "_poll_gap"}, g, PG);
        end
        exp_q.delete();
        obs_q.delete();
        idle_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_outs", {busy_o, done_o, timeout_o, aborted_o, err_o, cfg_valid_o, cfg_rwn_o,
                         cfg_addr_o, cfg_data_o}, 45'd0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle_after_rst", {busy_o, cfg_valid_o}, 2'b00);

        // 1: ready immediate, full job
        push_normal(32'h00A0_0306, 12'h123, 16'd8, 0, 0);
        run_job("t1", 16'h00A0, 2'd3, 1'b0, 1'b0, 12'h123, 16'd8, 16'd0);
        wait_done("t1", 1'b0);
        cmp_q("t1");
        chk("t1_flags", {timeout_o, aborted_o, err_o}, 4'b0000);

        // 2: size 0 -> setup then error read only
        err_val = 2'b01;
        push_normal(32'h1234_030B, 12'h0AB, 16'd0, 0, 0);
        run_job("t2", 16'h1234, 2'd1, 1'b1, 1'b1, 12'h0AB, 16'd0, 16'd0);
        wait_done("t2", 1'b0);
        cmp_q("t2");
        chk("t2_err", {timeout_o, aborted_o, err_o}, 4'b0001);

        // 3: three-cycle stall on every transfer
        stall_n = 3;
        err_val = 2'b10;
        push_normal(32'h0008_030C, 12'hFFF, 16'd5, 0, 0);
        run_job("t3", 16'h0008, 2'd2, 1'b0, 1'b1, 12'hFFF, 16'd5, 16'd0);
        wait_done("t3", 1'b0);
        cmp_q("t3");
        chk("t3_err", {timeout_o, aborted_o, err_o}, 4'b0010);

        // 4: pending for 5 polls, busy for 2; a second start while busy is ignored
        stall_n = 0;
        err_val = 2'b00;
        pend_n  = 5;
        busy_n  = 2;
        push_normal(32'h0100_0300, 12'h010, 16'd3, 5, 2);
        run_job("t4", 16'h0100, 2'd0, 1'b0, 1'b0, 12'h010, 16'd3, 16'd0);
        repeat (7) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done("t4", 1'b0);
        cmp_q("t4");
        chk("t4_flags", {timeout_o, aborted_o, err_o}, 4'b0000);

        // 5: pending stuck, timeout 20 -> clear write
        pend_n = 0;
        busy_n = 0;
        stuck  = 1'b1;
        exp_q.push_back(wr(5'd9, 32'h00A0_0306));
        exp_q.push_back(wr(5'd4, 32'h40));
        exp_q.push_back(wr(5'd5, 32'h10));
        exp_q.push_back(wr(5'd6, 32'h10));
        for (int i = 0; i < 4; i++) exp_q.push_back(rd(5'd6));
        exp_q.push_back(wr(5'd6, 32'h20));
        run_job("t5", 16'h00A0, 2'd3, 1'b0, 1'b0, 12'h040, 16'd16, 16'd20);
        wait_done("t5", 1'b0);
        cmp_q("t5");
        chk("t5_flags", {timeout_o, aborted_o, err_o}, 4'b1000);

        // 6: abort while SIZE write is stalled
        stuck   = 1'b0;
        stall_n = 10;
        err_val = 2'b11;
        exp_q.push_back(wr(5'd9, 32'h00A0_0306));
        exp_q.push_back(wr(5'd4, 32'h77));
        exp_q.push_back(wr(5'd6, 32'h20));
        run_job("t6", 16'h00A0, 2'd3, 1'b0, 1'b0, 12'h077, 16'd8, 16'd0);
        begin
            bit found = 1'b0;
            for (int i = 0; i < 300 && !found; i++) begin
                @(negedge clk_i);
                if (cfg_valid_o && cfg_addr_o == 5'd5) found = 1'b1;
            end
            chk("t6_size_seen", found, 1'b1);
        end
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("t6_valid_drop", cfg_valid_o, 1'b0);
        chk("t6_aborted", aborted_o, 1'b1);
        wait_done("t6", 1'b0);
        cmp_q("t6");
        chk("t6_flags", {timeout_o, aborted_o, err_o}, 4'b0100);

        // 7: normal run returns error 2'b10; abort during DONE is ignored
        stall_n = 1;
        err_val = 2'b10;
        push_normal(32'h0020_0302, 12'h200, 16'd2, 0, 0);
        run_job("t7", 16'h0020, 2'd1, 1'b0, 1'b0, 12'h200, 16'd2, 16'd0);
        wait_done("t7", 1'b1);
        cmp_q("t7");
        chk("t7_flags", {timeout_o, aborted_o, err_o}, 4'b0010);

        // 8: reset mid-job returns to idle with no clear write
        stall_n = 0;
        run_job("t8", 16'h0001, 2'd0, 1'b0, 1'b0, 12'h001, 16'd4, 16'd0);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        chk("t8_rst_outs", {busy_o, cfg_valid_o, done_o, err_o}, 5'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        obs_q.delete();
        idle_q.delete();
        repeat (10) @(negedge clk_i);
        chk("t8_no_bus", {obs_q.size() != 0, busy_o}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
